mmcm_reset_ctrl: RTL and testbench
==================================

# mmcm_reset_ctrl

Controls the reset side of the clock manager. It drives the MMCM `RST` input, monitors the MMCM `LOCKED` output, and releases a clean system reset only after lock has been continuously stable. It sits beside the clock manager on the free-running board reference clock. It re-initialises the MMCM on lock timeout, on lock loss, or on software request.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 8: width of the MMCM reset pulse in `clk_i` cycles. Must be ≥ 4 so that the synchronised lock flag is low before WAIT_LOCK.
- `LOCK_TIMEOUT`, 4096: maximum cycles spent in WAIT_LOCK per attempt.
- `STABLE_CYCLES`, 256: number of consecutive synchronised-lock cycles required before release.
- `MAX_RETRIES`, 3: number of re-attempts after the first timeout before entering FAIL.
- `CNT_W`, 8: width of the relock counter.

Ports:
- `clk_i`, in, 1: free-running reference clock (the MMCM input clock).
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `locked_i`, in, 1: MMCM `LOCKED`. Asynchronous to `clk_i`; passes through a 2-flop synchroniser.
- `restart_i`, in, 1: single-cycle request to re-initialise the MMCM.
- `mmcm_rst_o`, out, 1: drives MMCM `RST`, active-high.
- `sys_rstn_o`, out, 1: active-low system reset. Registered, glitch-free.
- `ready_o`, out, 1: high while in RUN.
- `fail_o`, out, 1: high while in FAIL.
- `relock_cnt_o`, out, `CNT_W`: number of lock losses seen in RUN. Saturates at all-ones.

## Operation
- `locked_s` is `locked_i` after 2 flops. All FSM decisions use `locked_s` only.
- States are RESET_MMCM, WAIT_LOCK, STABLE, RUN and FAIL. There is one shared down/up counter, cleared on every state entry, plus a retry counter.
- RESET_MMCM: `mmcm_rst_o`=1. After `RST_PULSE_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `mmcm_rst_o`=0.
  - If `locked_s`=1, go to STABLE.
  - Else, once the counter reaches `LOCK_TIMEOUT`: if retry < `MAX_RETRIES`, increment retry and go to RESET_MMCM; otherwise go to FAIL.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE: count consecutive `locked_s`=1 cycles.
  - If `locked_s`=0, go to RESET_MMCM and increment retry (FAIL if retry is already `MAX_RETRIES`).
  - At `STABLE_CYCLES`, go to RUN and clear retry.
- RUN: `sys_rstn_o`=1, `ready_o`=1.
  - If `locked_s`=0, go to RESET_MMCM, increment `relock_cnt_o` (saturating), and clear retry.
- FAIL: `mmcm_rst_o`=0, `sys_rstn_o`=0, `fail_o`=1. Exits only via `restart_i` or `rstn_i`.
- `restart_i`=1 in any state: go to RESET_MMCM next cycle and clear retry. Does not touch `relock_cnt_o`.
- Priority: `restart_i` > lock loss > timeout/stable completion.
- `sys_rstn_o` is 1 only in RUN and drops in the first cycle after RUN is left. `ready_o` is identical to `sys_rstn_o`.

## Timing
- During `rstn_i`=0: `mmcm_rst_o`=1, `sys_rstn_o`=0, `ready_o`=0, `fail_o`=0, `relock_cnt_o`=0, retry=0, synchroniser flops=0, state=RESET_MMCM with counter 0.
- After `rstn_i` is released, `mmcm_rst_o` stays high for exactly `RST_PULSE_CYCLES` rising edges.
- Lock acceptance: the first `locked_i`=1 sample reaches `locked_s` 2 cycles later. STABLE is entered 1 cycle after that. `sys_rstn_o` rises `STABLE_CYCLES` cycles after STABLE entry, i.e. 3 + `STABLE_CYCLES` cycles after the `locked_i` edge.
- Lock loss in RUN: `sys_rstn_o` falls 3 cycles after `locked_i` falls (2 synchroniser + 1 registered). `mmcm_rst_o` rises in the same cycle.
- Timeout: from WAIT_LOCK entry to RESET_MMCM entry is `LOCK_TIMEOUT`+1 cycles.
- Asserting `rstn_i` mid-operation forces the reset values immediately (asynchronously), including clearing `relock_cnt_o`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.

- **Nominal:** release `rstn_i`; raise `locked_i` 10 cycles later.
  - `mmcm_rst_o` is high for 4 cycles.
  - `sys_rstn_o`/`ready_o` rise 11 cycles after the `locked_i` edge.
  - `fail_o`=0 and `relock_cnt_o`=0.
- **Glitch in STABLE:** `locked_i` high for 5 cycles, then low for 1 cycle.
  - New 4-cycle `mmcm_rst_o` pulse.
  - `sys_rstn_o` never rises.
  - A subsequent clean lock is accepted.
- **Timeout/fail:** keep `locked_i`=0.
  - Exactly 3 `mmcm_rst_o` pulses, then `fail_o`=1 and `sys_rstn_o`=0.
  - `fail_o` holds for 100 cycles.
  - A `restart_i` pulse gives `fail_o`=0 and a new pulse.
- **Lock loss in RUN:** drop `locked_i` while in RUN, then re-lock; repeat 3 times.
  - `sys_rstn_o` falls 3 cycles after each drop.
  - `relock_cnt_o` reads 1, 2, 3.
  - `fail_o` stays 0.
- **Simultaneity:**
  - `restart_i` in the same cycle as a lock loss in RUN gives RESET_MMCM with `relock_cnt_o` unchanged.
  - `locked_s` rising on the timeout cycle enters STABLE.
- **Async reset mid-STABLE:** assert `rstn_i`=0 for 1 cycle.
  - All outputs take their reset values without waiting for a clock edge.
  - `relock_cnt_o`=0.

Source files
------------

// File: rtl/mmcm_reset_ctrl.sv
// mmcm_reset_ctrl
// Drives the MMCM RST input and watches LOCKED. The system reset is released
// only after LOCKED has been continuously stable. The MMCM is re-initialised
// on lock timeout, on lock loss, or on a restart request. A bounded number of
// retries is allowed before the block parks in FAIL.
// RST_PULSE_CYCLES must be at least 4, so that the synchronised lock flag has
// dropped before WAIT_LOCK is entered.
module mmcm_reset_ctrl #(
  parameter int RST_PULSE_CYCLES = 8,
  parameter int LOCK_TIMEOUT     = 4096,
  parameter int STABLE_CYCLES    = 256,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             locked_i,
  input  logic             restart_i,
  output logic             mmcm_rst_o,
  output logic             sys_rstn_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  // The shared timer must reach the largest terminal value of any state.
  localparam int TMR_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > RST_PULSE_CYCLES) ? TMR_MAX_A : RST_PULSE_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int RTY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Terminal timer values. The reset pulse and the stable window end on the
  // last counted cycle. The timeout fires one cycle after the count reaches
  // LOCK_TIMEOUT, which gives LOCK_TIMEOUT+1 cycles in WAIT_LOCK.
  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_MMCM,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic [CNT_W-1:0] relock_nxt;
  logic             enter;
  logic [1:0]       lock_sync_q;
  logic             locked_s;

  // Two-flop synchroniser for the asynchronous LOCKED flag.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge inputs and the two stages do not collapse into one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], locked_i};
    end
  end

  assign locked_s = lock_sync_q[1];

  // Next-state decision. The priority is: restart, then lock loss, then
  // timeout or stable completion.
  // NOTE: every variable gets a default before the case statement. This keeps
  // the block purely combinational and avoids inferred latches.
  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry;
    relock_nxt = relock_cnt_o;
    enter      = 1'b0;

    if (restart_i) begin
      state_nxt = RESET_MMCM;
      retry_nxt = '0;
      enter     = 1'b1;
    end else begin
      unique case (state)
        RESET_MMCM: begin
          if (tmr == PULSE_LAST) begin
            state_nxt = WAIT_LOCK;
            enter     = 1'b1;
          end
        end

        WAIT_LOCK: begin
          // A lock seen on the timeout cycle still counts as a lock.
          if (locked_s) begin
            state_nxt = STABLE;
            enter     = 1'b1;
          end else if (tmr == TIMEOUT_LAST) begin
            enter = 1'b1;
            if (retry < RETRY_MAX) begin
              retry_nxt = retry + 1'b1;
              state_nxt = RESET_MMCM;
            end else begin
              state_nxt = FAIL;
            end
          end
        end

        STABLE: begin
          if (!locked_s) begin
            enter = 1'b1;
            if (retry >= RETRY_MAX) begin
              state_nxt = FAIL;
            end else begin
              retry_nxt = retry + 1'b1;
              state_nxt = RESET_MMCM;
            end
          end else if (tmr == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
            enter     = 1'b1;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_nxt = RESET_MMCM;
            retry_nxt = '0;
            enter     = 1'b1;
            if (relock_cnt_o != '1) begin
              relock_nxt = relock_cnt_o + 1'b1;
            end
          end
        end

        FAIL: begin
          state_nxt = FAIL;
        end

        default: begin
          state_nxt = RESET_MMCM;
          retry_nxt = '0;
          enter     = 1'b1;
        end
      endcase
    end

    // The timer restarts on every state entry. It idles at zero in the
    // states that do not time anything.
    if (enter || (state_nxt == RUN) || (state_nxt == FAIL)) begin
      tmr_nxt = '0;
    end else begin
      tmr_nxt = tmr + 1'b1;
    end
  end

  // State, counters and registered outputs. Each output is decoded from the
  // next state, so it changes on the same edge as the state and cannot glitch.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= RESET_MMCM;
      tmr          <= '0;
      retry        <= '0;
      relock_cnt_o <= '0;
      mmcm_rst_o   <= 1'b1;
      sys_rstn_o   <= 1'b0;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      retry        <= retry_nxt;
      relock_cnt_o <= relock_nxt;
      mmcm_rst_o   <= (state_nxt == RESET_MMCM);
      sys_rstn_o   <= (state_nxt == RUN);
      ready_o      <= (state_nxt == RUN);
      fail_o       <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_mmcm_reset_ctrl.sv
// tb_mmcm_reset_ctrl
// Scenario tasks for mmcm_reset_ctrl. Lock delays and dwell times are random.
// Expected latencies come from the timing rules: 2 synchroniser cycles, then
// 1 registered decision, then the pulse, timeout and stable windows.
module tb_mmcm_reset_ctrl;

  localparam int RST_PULSE  = 4;
  localparam int TIMEOUT    = 20;
  localparam int STABLE_N   = 8;
  localparam int RETRIES    = 2;
  localparam int CW         = 2;
  localparam int RELOCK_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          locked_i;
  logic          restart_i;
  logic          mmcm_rst_o;
  logic          sys_rstn_o;
  logic          ready_o;
  logic          fail_o;
  logic [CW-1:0] relock_cnt_o;

  int total = 0;
  int bad   = 0;
  int relock_exp = 0;

  always #5 clk_i = ~clk_i;

  mmcm_reset_ctrl #(
    .RST_PULSE_CYCLES(RST_PULSE),
    .LOCK_TIMEOUT    (TIMEOUT),
    .STABLE_CYCLES   (STABLE_N),
    .MAX_RETRIES     (RETRIES),
    .CNT_W           (CW)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .locked_i    (locked_i),
    .restart_i   (restart_i),
    .mmcm_rst_o  (mmcm_rst_o),
    .sys_rstn_o  (sys_rstn_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .relock_cnt_o(relock_cnt_o)
  );

  // Outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  // Counts consecutive high samples of mmcm_rst_o, starting from the current one.
  task automatic measure_pulse(output int w);
    w = 0;
    while (mmcm_rst_o === 1'b1 && w < 50) begin
      w++;
      tick();
    end
  endtask

  // Counts cycles until sys_rstn_o rises and notes any mmcm_rst_o activity.
  task automatic ticks_to_run(input int budget, output int n, output bit saw_mmcm);
    n = 0;
    saw_mmcm = 1'b0;
    while (sys_rstn_o !== 1'b1 && n < budget) begin
      tick();
      n++;
      if (mmcm_rst_o === 1'b1) saw_mmcm = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; locked_i = 1'b0; restart_i = 1'b0;
    repeat (3) tick();
    total++; if (mmcm_rst_o !== 1'b1) begin bad++; $display("FAIL reset_mmcm_rst: got %b want 1", mmcm_rst_o); end
    total++; if (sys_rstn_o !== 1'b0) begin bad++; $display("FAIL reset_sys_rstn: got %b want 0", sys_rstn_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail_o); end
    total++; if (relock_cnt_o !== '0) begin bad++; $display("FAIL reset_relock: got %0d want 0", relock_cnt_o); end
  endtask

  task automatic test_nominal();
    int w, n, e;
    bit saw;
    rstn_i = 1'b1;
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL nominal_pulse: got %0d want %0d", w, RST_PULSE); end
    e = $urandom_range(0, 15);
    repeat (e) tick();
    locked_i = 1'b1;
    ticks_to_run(60, n, saw);
    total++; if (n != 3 + STABLE_N) begin bad++; $display("FAIL nominal_latency: got %0d want %0d", n, 3 + STABLE_N); end
    total++; if (saw) begin bad++; $display("FAIL nominal_no_mmcm: got 1 want 0"); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL nominal_ready: got %b want 1", ready_o); end
    total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL nominal_fail: got %b want 0", fail_o); end
    total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL nominal_relock: got %0d want %0d", relock_cnt_o, relock_exp); end
  endtask

  task automatic test_glitch_stable();
    int w, n, e, hi;
    bit saw_run, saw;
    // Leave RUN through a restart while the lock is removed.
    locked_i = 1'b0; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    total++; if (sys_rstn_o !== 1'b0) begin bad++; $display("FAIL restart_drop: got %b want 0", sys_rstn_o); end
    total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL restart_relock: got %0d want %0d", relock_cnt_o, relock_exp); end
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL restart_pulse: got %0d want %0d", w, RST_PULSE); end
    // A short lock, then one low cycle, then the lock returns.
    e  = $urandom_range(0, 10);
    hi = $urandom_range(1, STABLE_N);
    repeat (e) tick();
    locked_i = 1'b1;
    saw_run = 1'b0;
    repeat (hi) begin
      tick();
      if (sys_rstn_o === 1'b1) saw_run = 1'b1;
    end
    locked_i = 1'b0;
    tick();
    if (sys_rstn_o === 1'b1) saw_run = 1'b1;
    locked_i = 1'b1;
    n = 1;
    while (mmcm_rst_o !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (sys_rstn_o === 1'b1) saw_run = 1'b1;
    end
    total++; if (n != 3) begin bad++; $display("FAIL glitch_reset_delay: got %0d want 3 (hi=%0d)", n, hi); end
    total++; if (saw_run) begin bad++; $display("FAIL glitch_no_release: got 1 want 0 (hi=%0d)", hi); end
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL glitch_pulse: got %0d want %0d", w, RST_PULSE); end
    // The lock is already present when WAIT_LOCK starts, so STABLE follows one cycle later.
    ticks_to_run(60, n, saw);
    total++; if (n != 1 + STABLE_N) begin bad++; $display("FAIL glitch_relock: got %0d want %0d", n, 1 + STABLE_N); end
    total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL glitch_fail: got %b want 0", fail_o); end
  endtask

  task automatic test_lock_loss();
    int w, n, e, r;
    bit saw;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(1, 10);
      repeat (r) tick();
      total++; if (sys_rstn_o !== 1'b1) begin bad++; $display("FAIL run_hold[%0d]: got %b want 1", i, sys_rstn_o); end
      locked_i = 1'b0;
      repeat (2) tick();
      total++; if (sys_rstn_o !== 1'b1 || mmcm_rst_o !== 1'b0) begin
        bad++; $display("FAIL loss_early[%0d]: got rstn=%b rst=%b want 1/0", i, sys_rstn_o, mmcm_rst_o);
      end
      tick();
      total++; if (sys_rstn_o !== 1'b0 || ready_o !== 1'b0 || mmcm_rst_o !== 1'b1) begin
        bad++; $display("FAIL loss_fall[%0d]: got rstn=%b ready=%b rst=%b want 0/0/1", i, sys_rstn_o, ready_o, mmcm_rst_o);
      end
      relock_exp = (relock_exp >= RELOCK_MAX) ? RELOCK_MAX : relock_exp + 1;
      total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL loss_relock[%0d]: got %0d want %0d", i, relock_cnt_o, relock_exp); end
      total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL loss_fail[%0d]: got %b want 0", i, fail_o); end
      measure_pulse(w);
      total++; if (w != RST_PULSE) begin bad++; $display("FAIL loss_pulse[%0d]: got %0d want %0d", i, w, RST_PULSE); end
      e = $urandom_range(0, 15);
      repeat (e) tick();
      locked_i = 1'b1;
      ticks_to_run(60, n, saw);
      total++; if (n != 3 + STABLE_N || saw) begin bad++; $display("FAIL loss_relock_time[%0d]: got %0d want %0d", i, n, 3 + STABLE_N); end
    end
  endtask

  task automatic test_simultaneous();
    int w, n;
    bit saw;
    // The restart lands on the same edge that first sees the lock loss.
    locked_i = 1'b0;
    repeat (2) tick();
    total++; if (sys_rstn_o !== 1'b1) begin bad++; $display("FAIL simul_pre: got %b want 1", sys_rstn_o); end
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    total++; if (mmcm_rst_o !== 1'b1 || sys_rstn_o !== 1'b0) begin
      bad++; $display("FAIL simul_state: got rst=%b rstn=%b want 1/0", mmcm_rst_o, sys_rstn_o);
    end
    total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL simul_relock: got %0d want %0d", relock_cnt_o, relock_exp); end
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL simul_pulse: got %0d want %0d", w, RST_PULSE); end
    // The synchronised lock first appears on the timeout cycle of WAIT_LOCK.
    repeat (TIMEOUT - 2) tick();
    locked_i = 1'b1;
    ticks_to_run(60, n, saw);
    total++; if (n != 3 + STABLE_N) begin bad++; $display("FAIL timeout_edge_lock: got %0d want %0d", n, 3 + STABLE_N); end
    total++; if (saw) begin bad++; $display("FAIL timeout_edge_no_reset: got 1 want 0"); end
  endtask

  task automatic test_timeout_fail();
    int w, g, pulses, viol;
    locked_i = 1'b0; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    pulses = 0;
    for (int p = 0; p < 6 && fail_o !== 1'b1; p++) begin
      measure_pulse(w);
      pulses++;
      total++; if (w != RST_PULSE) begin bad++; $display("FAIL tmo_pulse[%0d]: got %0d want %0d", p, w, RST_PULSE); end
      g = 0;
      while (mmcm_rst_o !== 1'b1 && fail_o !== 1'b1 && g < 100) begin
        g++;
        tick();
      end
      total++; if (g != TIMEOUT + 1) begin bad++; $display("FAIL tmo_wait[%0d]: got %0d want %0d", p, g, TIMEOUT + 1); end
    end
    total++; if (pulses != RETRIES + 1) begin bad++; $display("FAIL tmo_pulse_count: got %0d want %0d", pulses, RETRIES + 1); end
    total++; if (fail_o !== 1'b1 || sys_rstn_o !== 1'b0) begin
      bad++; $display("FAIL tmo_fail_state: got fail=%b rstn=%b want 1/0", fail_o, sys_rstn_o);
    end
    viol = 0;
    repeat (100) begin
      tick();
      if (fail_o !== 1'b1 || sys_rstn_o !== 1'b0 || mmcm_rst_o !== 1'b0 || ready_o !== 1'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL fail_hold: got %0d bad cycles want 0", viol); end
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    total++; if (fail_o !== 1'b0 || mmcm_rst_o !== 1'b1) begin
      bad++; $display("FAIL fail_restart: got fail=%b rst=%b want 0/1", fail_o, mmcm_rst_o);
    end
    total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL fail_relock: got %0d want %0d", relock_cnt_o, relock_exp); end
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL fail_restart_pulse: got %0d want %0d", w, RST_PULSE); end
  endtask

  task automatic test_async_reset();
    int w, n, k;
    bit saw;
    // Enter STABLE and stop part-way through the stable window.
    k = $urandom_range(1, 6);
    locked_i = 1'b1;
    repeat (3 + k) tick();
    total++; if (sys_rstn_o !== 1'b0 || mmcm_rst_o !== 1'b0) begin
      bad++; $display("FAIL mid_stable: got rstn=%b rst=%b want 0/0", sys_rstn_o, mmcm_rst_o);
    end
    total++; if (relock_cnt_o !== CW'(relock_exp)) begin bad++; $display("FAIL pre_reset_relock: got %0d want %0d", relock_cnt_o, relock_exp); end
    #2 rstn_i = 1'b0;
    #1;
    total++; if (mmcm_rst_o !== 1'b1) begin bad++; $display("FAIL async_mmcm_rst: got %b want 1", mmcm_rst_o); end
    total++; if (sys_rstn_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++; $display("FAIL async_rstn: got rstn=%b ready=%b want 0/0", sys_rstn_o, ready_o);
    end
    total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL async_fail: got %b want 0", fail_o); end
    total++; if (relock_cnt_o !== '0) begin bad++; $display("FAIL async_relock: got %0d want 0", relock_cnt_o); end
    relock_exp = 0;
    tick();
    rstn_i = 1'b1;
    measure_pulse(w);
    total++; if (w != RST_PULSE) begin bad++; $display("FAIL async_pulse: got %0d want %0d", w, RST_PULSE); end
    ticks_to_run(60, n, saw);
    total++; if (n != 1 + STABLE_N) begin bad++; $display("FAIL async_recover: got %0d want %0d", n, 1 + STABLE_N); end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_glitch_stable();
    test_lock_loss();
    test_simultaneous();
    test_timeout_fail();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
